// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Frame states, legal prescale ratios and the parity helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int PRESCALE_8   = 8;
    localparam int PRESCALE_16  = 16;
    localparam int PRESCALE_32  = 32;
    localparam int PRESCALE_DEF = PRESCALE_8;

    // Expected parity bit: odd parity inverts the XOR of the data bits.
    function automatic logic parity_of(
        input logic [31:0] data,
        input logic        odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 2-of-3 majority sampler around mid-bit.
// Strobes tell the frame FSM when a bit value and a bit end are ready.
module uart_rx_sampler
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  start,
    input  logic                  run,
    input  logic                  abort,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sample_done,
    output logic                  bit_val,
    output logic                  bit_done
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic                  s0;
    logic                  s1;

    assign half        = prescale >> 1;
    assign sample_done = run && (edge_cnt == half + ONE);
    assign bit_done    = run && (edge_cnt == prescale - ONE);
    // Third sample is the live line, so the vote lands on the h+1 edge.
    assign bit_val     = (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            s0       <= 1'b0;
            s1       <= 1'b0;
        end else begin
            if (start) begin
                edge_cnt <= ONE;
            end else if (!run || abort || bit_done) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + ONE;
            end
            if (run && (edge_cnt == half - ONE)) begin
                s0 <= rx_in;
            end
            if (run && (edge_cnt == half)) begin
                s1 <= rx_in;
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver frame FSM: start/data/parity/stop handling.
// Delivers P_DATA with DATA_VALID, or PAR_ERR/STP_ERR pulses.
module uart_rx_frame
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    import uart_rx_pkg::*;

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    rx_state_e             state;
    logic [PRESCALE_W-1:0] pre_q;
    logic [PRESCALE_W-1:0] pre_sel;
    logic                  pre_ok;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bad;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  start;
    logic                  run;
    logic                  abort;
    logic                  sample_done;
    logic                  bit_val;
    logic                  bit_done;

    assign pre_ok  = (PRESCALE == PRESCALE_W'(PRESCALE_8))
                  || (PRESCALE == PRESCALE_W'(PRESCALE_16))
                  || (PRESCALE == PRESCALE_W'(PRESCALE_32));
    assign pre_sel = pre_ok ? PRESCALE : PRESCALE_W'(PRESCALE_DEF);

    assign start = (state == IDLE) && !RX_IN;
    assign run   = (state != IDLE);
    assign abort = (state == START) && sample_done && bit_val;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk         (CLK),
        .rst         (RST),
        .rx_in       (RX_IN),
        .start       (start),
        .run         (run),
        .abort       (abort),
        .prescale    (pre_q),
        .sample_done (sample_done),
        .bit_val     (bit_val),
        .bit_done    (bit_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            pre_q      <= PRESCALE_W'(PRESCALE_DEF);
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad    <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        state     <= START;
                        pre_q     <= pre_sel;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_bad   <= 1'b0;
                        bit_cnt   <= '0;
                    end
                end
                START: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (bit_done) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (sample_done) begin
                        shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
                    end
                    if (bit_done) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (sample_done) begin
                        par_bad <= bit_val
                                != parity_of(32'(shreg), par_typ_q);
                    end
                    if (bit_done) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Errored frames never disturb the last good word.
                    if (sample_done) begin
                        if (par_bad || !bit_val) begin
                            PAR_ERR <= par_bad;
                            STP_ERR <= !bit_val;
                        end else begin
                            DATA_VALID <= 1'b1;
                            P_DATA     <= shreg;
                        end
                    end
                    if (bit_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame.
// Line waveforms and expected events come from a frame-level model.
module tb_uart_rx_frame;

    localparam int W  = 8;
    localparam int PW = 6;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          rx_in    = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          par_en   = 1'b0;
    logic          par_typ  = 1'b0;
    logic [W-1:0]  p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    int checks   = 0;
    int failures = 0;

    logic          wv[$];
    logic [PW-1:0] wv_p[$];
    logic          wv_pe[$];
    logic          wv_pt[$];
    int            exp_cyc[$];
    logic [2:0]    exp_kind[$];
    logic [W-1:0]  exp_dat[$];
    int            obs_cyc[$];
    logic [2:0]    obs_kind[$];
    logic [W-1:0]  obs_dat[$];
    logic [W-1:0]  model_pdata = '0;

    uart_rx_frame #(
        .DATA_WIDTH (W),
        .PRESCALE_W (PW)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .RX_IN      (rx_in),
        .PRESCALE   (prescale),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_ERR    (par_err),
        .STP_ERR    (stp_err)
    );

    always #5 clk = ~clk;

    task automatic clear_all();
        wv.delete(); wv_p.delete(); wv_pe.delete(); wv_pt.delete();
        exp_cyc.delete(); exp_kind.delete(); exp_dat.delete();
    endtask

    // One line cycle; configuration is noise except on a start cycle.
    task automatic push_cyc(input logic lvl);
        wv.push_back(lvl);
        wv_p.push_back(PW'($urandom));
        wv_pe.push_back(1'($urandom));
        wv_pt.push_back(1'($urandom));
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) push_cyc(1'b1);
    endtask

    task automatic add_frame(input logic [W-1:0] d, input int pres,
                             input bit pen, input bit pt, input bit flip,
                             input bit stopb, input bit glitch,
                             output int s);
        int   p;
        int   b;
        int   off;
        logic pb;
        logic perr;
        logic serr;
        logic bits[$];
        p  = (pres == 8 || pres == 16 || pres == 32) ? pres : 8;
        pb = (^d) ^ pt ^ flip;
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pb);
        bits.push_back(stopb);
        s = wv.size();
        foreach (bits[k]) begin
            for (int j = 0; j < p; j++) push_cyc(bits[k]);
        end
        wv_p[s]  = PW'(pres);
        wv_pe[s] = pen;
        wv_pt[s] = pt;
        if (glitch) begin
            b   = $urandom_range(bits.size() - 1, 0);
            off = p / 2 - 1 + $urandom_range(2, 0);
            wv[s + b * p + off] = ~wv[s + b * p + off];
        end
        perr = pen && (pb != ((^d) ^ pt));
        serr = !stopb;
        if (!perr && !serr) model_pdata = d;
        exp_cyc.push_back(s + (bits.size() - 1) * p + p / 2 + 2);
        exp_kind.push_back({serr, perr, !perr && !serr});
        exp_dat.push_back(model_pdata);
    endtask

    task automatic drive(input int rst_at, input int rst_len);
        obs_cyc.delete(); obs_kind.delete(); obs_dat.delete();
        for (int k = 0; k < wv.size(); k++) begin
            @(negedge clk);
            rx_in    = wv[k];
            prescale = wv_p[k];
            par_en   = wv_pe[k];
            par_typ  = wv_pt[k];
            rst      = (k >= rst_at) && (k < rst_at + rst_len);
            #1;
            if ((data_valid | par_err | stp_err) !== 1'b0) begin
                obs_cyc.push_back(k);
                obs_kind.push_back({stp_err, par_err, data_valid});
                obs_dat.push_back(p_data);
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({p_data, data_valid, par_err, stp_err} !== '0) begin
            failures++;
            $display("FAIL reset got pdata=%h dv=%b pe=%b se=%b want all 0",
                     p_data, data_valid, par_err, stp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        model_pdata = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_prescales();
        int s;
        clear_all();
        add_frame(8'hA5, 8, 1, 0, 0, 1, 0, s);
        add_idle(5);
        add_frame(8'h3C, 16, 0, 0, 0, 1, 0, s);
        add_idle(3);
        add_frame(8'h3C, 32, 0, 1, 0, 1, 0, s);
        add_idle(8);
        drive(-1, 0);
        checks++;
        if (obs_cyc.size() !== exp_cyc.size()) begin
            failures++;
            $display("FAIL prescale count got %0d want %0d",
                     obs_cyc.size(), exp_cyc.size());
        end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_kind[i] !== exp_kind[i]
                || obs_dat[i] !== exp_dat[i]) begin
                failures++;
                $display("FAIL prescale ev%0d got c=%0d k=%b d=%h want c=%0d k=%b d=%h",
                         i, obs_cyc[i], obs_kind[i], obs_dat[i],
                         exp_cyc[i], exp_kind[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_errors();
        int s;
        clear_all();
        add_frame(8'h3C, 8, 1, 0, 0, 1, 0, s);
        add_idle(4);
        add_frame(8'h01, 8, 1, 0, 1, 1, 0, s);
        add_idle(4);
        add_frame(8'h55, 8, 0, 0, 0, 0, 0, s);
        add_idle(4);
        add_frame(8'h80, 8, 1, 1, 1, 0, 0, s);
        add_idle(8);
        drive(-1, 0);
        checks++;
        if (obs_cyc.size() !== exp_cyc.size()) begin
            failures++;
            $display("FAIL errors count got %0d want %0d",
                     obs_cyc.size(), exp_cyc.size());
        end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_kind[i] !== exp_kind[i]
                || obs_dat[i] !== exp_dat[i]) begin
                failures++;
                $display("FAIL errors ev%0d got c=%0d k=%b d=%h want c=%0d k=%b d=%h",
                         i, obs_cyc[i], obs_kind[i], obs_dat[i],
                         exp_cyc[i], exp_kind[i], exp_dat[i]);
            end
        end
        checks++;
        if (p_data !== model_pdata) begin
            failures++;
            $display("FAIL errors_hold got %h want %h", p_data, model_pdata);
        end
    endtask

    task automatic test_false_start_glitch();
        int s;
        clear_all();
        push_cyc(1'b0);
        push_cyc(1'b0);
        for (int i = 0; i < 4; i++) push_cyc(1'b1);
        add_frame(8'hB7, 8, 0, 0, 0, 1, 0, s);
        wv[s + 4 * 8 + 2] = ~wv[s + 4 * 8 + 2];
        wv[s + 4 * 8 + 3] = ~wv[s + 4 * 8 + 3];
        add_idle(8);
        drive(-1, 0);
        checks++;
        if (obs_cyc.size() !== exp_cyc.size()) begin
            failures++;
            $display("FAIL false_start count got %0d want %0d",
                     obs_cyc.size(), exp_cyc.size());
        end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_kind[i] !== exp_kind[i]
                || obs_dat[i] !== exp_dat[i]) begin
                failures++;
                $display("FAIL false_start ev%0d got c=%0d k=%b d=%h want c=%0d k=%b d=%h",
                         i, obs_cyc[i], obs_kind[i], obs_dat[i],
                         exp_cyc[i], exp_kind[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s;
        clear_all();
        add_frame(8'h12, 8, 0, 0, 0, 1, 0, s);
        add_frame(8'h34, 8, 0, 0, 0, 1, 0, s);
        add_frame(8'h56, 8, 0, 0, 0, 1, 0, s);
        for (int k = s + 30; k < wv.size(); k++) wv[k] = 1'b1;
        void'(exp_cyc.pop_back());
        void'(exp_kind.pop_back());
        void'(exp_dat.pop_back());
        add_idle(20);
        drive(s + 20, 3);
        checks++;
        if (obs_cyc.size() !== exp_cyc.size()) begin
            failures++;
            $display("FAIL b2b count got %0d want %0d",
                     obs_cyc.size(), exp_cyc.size());
        end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_kind[i] !== exp_kind[i]
                || obs_dat[i] !== exp_dat[i]) begin
                failures++;
                $display("FAIL b2b ev%0d got c=%0d k=%b d=%h want c=%0d k=%b d=%h",
                         i, obs_cyc[i], obs_kind[i], obs_dat[i],
                         exp_cyc[i], exp_kind[i], exp_dat[i]);
            end
        end
        model_pdata = '0;
        checks++;
        if (p_data !== model_pdata) begin
            failures++;
            $display("FAIL b2b_reset_pdata got %h want %h", p_data, model_pdata);
        end
    endtask

    task automatic test_break();
        int s;
        clear_all();
        for (int i = 0; i < 3; i++) add_frame(8'h00, 8, 1, 0, 0, 0, 0, s);
        add_idle(10);
        drive(-1, 0);
        checks++;
        if (obs_cyc.size() !== exp_cyc.size()) begin
            failures++;
            $display("FAIL break count got %0d want %0d",
                     obs_cyc.size(), exp_cyc.size());
        end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_kind[i] !== exp_kind[i]
                || obs_dat[i] !== exp_dat[i]) begin
                failures++;
                $display("FAIL break ev%0d got c=%0d k=%b d=%h want c=%0d k=%b d=%h",
                         i, obs_cyc[i], obs_kind[i], obs_dat[i],
                         exp_cyc[i], exp_kind[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_random();
        int s;
        int sel;
        int pres;
        clear_all();
        for (int f = 0; f < 24; f++) begin
            sel  = $urandom_range(5, 0);
            pres = (sel < 5) ? (8 << (sel % 3)) : $urandom_range(63, 0);
            add_frame(W'($urandom), pres, 1'($urandom), 1'($urandom),
                      ($urandom_range(3, 0) == 0), ($urandom_range(4, 0) != 0),
                      1'($urandom), s);
            add_idle($urandom_range(2, 0));
        end
        add_idle(8);
        drive(-1, 0);
        checks++;
        if (obs_cyc.size() !== exp_cyc.size()) begin
            failures++;
            $display("FAIL random count got %0d want %0d",
                     obs_cyc.size(), exp_cyc.size());
        end
        for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_cyc[i] !== exp_cyc[i] || obs_kind[i] !== exp_kind[i]
                || obs_dat[i] !== exp_dat[i]) begin
                failures++;
                $display("FAIL random ev%0d got c=%0d k=%b d=%h want c=%0d k=%b d=%h",
                         i, obs_cyc[i], obs_kind[i], obs_dat[i],
                         exp_cyc[i], exp_kind[i], exp_dat[i]);
            end
        end
        checks++;
        if (p_data !== model_pdata) begin
            failures++;
            $display("FAIL random_pdata got %h want %h", p_data, model_pdata);
        end
    endtask

    initial begin
        test_reset();
        test_prescales();
        test_errors();
        test_false_start_glitch();
        test_back_to_back();
        test_break();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Oversampled UART receiver that deserializes the serial RX_IN line into parallel bytes for the system's command/register path.
- Sits directly downstream of the RX_IN pad in the UART clock domain and feeds the RX-to-REF_CLK synchronizer / system controller.
- Supports a configurable oversampling prescale, optional even/odd parity, and parity and stop error detection. The error pulses drive the top-level RX_ERROR indication.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame, sent LSB first.
- PRESCALE_W, 6, width of the PRESCALE input.

Ports:
- CLK  input  1  oversampling clock (UART clock domain).
- RST  input  1  asynchronous reset, active-high.
- RX_IN  input  1  serial line, idle high. Already synchronous to CLK; the two-flop synchronizer lives at top level.
- PRESCALE  input  PRESCALE_W  oversampling ratio. Legal values are 8, 16 and 32.
- PAR_EN  input  1  1 means a parity bit follows the data bits.
- PAR_TYP  input  1  0 is even parity, 1 is odd parity.
- P_DATA  output  DATA_WIDTH  last received data word.
- DATA_VALID  output  1  one-cycle pulse marking a good frame.
- PAR_ERR  output  1  one-cycle pulse on a parity mismatch.
- STP_ERR  output  1  one-cycle pulse when the stop bit samples 0.

Behaviour:
- Reset (asynchronous, RST=1): all outputs 0, P_DATA=0, state IDLE, edge_cnt=0, bit_cnt=0.
- Configuration latch: PRESCALE, PAR_EN and PAR_TYP are latched when a start is detected and held for the whole frame. An illegal PRESCALE is treated as 8.
- States:
  - IDLE → START on the first CLK with RX_IN=0. That cycle is edge_cnt=0.
  - START → DATA, or back to IDLE on a false start.
  - DATA → PARITY if PAR_EN=1, otherwise → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- Bit timing: edge_cnt counts 0..P-1 within each bit, then wraps to 0 and advances the bit/state. P is the latched prescale.
- Sampling: with h=P/2, RX_IN is sampled at edge_cnt h-1, h and h+1. The bit value is the 2-of-3 majority, registered at edge_cnt h+2.
- False start: if the start bit majority is 1, return to IDLE at edge_cnt h+2. No output pulses.
- Data assembly: bits shift in LSB first; bit_cnt runs 0..DATA_WIDTH-1.
- Parity: the expected parity bit is XOR of the data bits, inverted when PAR_TYP=1. A mismatch is recorded internally and reported at stop time.
- Stop evaluation, at the stop-bit majority (edge_cnt h+2): outputs are registered and asserted exactly one cycle.
  - Good frame (no parity error and stop=1): P_DATA updates on the same edge as DATA_VALID. It holds until the next good frame and never changes on an errored frame.
  - Parity error: PAR_ERR=1, DATA_VALID=0.
  - Stop error (stop=0): STP_ERR=1, DATA_VALID=0.
  - Both errors: PAR_ERR and STP_ERR pulse together.
- End of frame: STOP stays until edge_cnt=P-1, then goes to IDLE.
  - Back-to-back frames: a new start bit on the very next CLK is accepted.
  - A held-low line (break) produces repeated frames, each with STP_ERR.
- Latency (start at cycle 0): DATA_VALID is high at cycle (N-1)*P + h + 2, where N = 1 + DATA_WIDTH + PAR_EN + 1 bits.
- Reset mid-frame: immediate return to IDLE, partial data discarded, no pulses.

Decomposition:
- Package uart_rx_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - legal prescale constants 8/16/32 and the default prescale 8;
  - a parity-function helper.
- Sub-module uart_rx_sampler: edge counter, the three-point majority sampler, and the sample_done/bit_done strobes. The top FSM consumes those strobes.

Test Plan:
- PRESCALE=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 → DATA_VALID high only at cycle 86, P_DATA=0xA5, no error pulses.
- PRESCALE=16, PAR_EN=0, frame 0x3C → DATA_VALID at cycle 154, P_DATA=0x3C. Repeat with PRESCALE=32 → cycle 306.
- PRESCALE=8, even parity, 0x01 sent with parity bit 0 → PAR_ERR pulse at cycle 86, DATA_VALID=0, P_DATA keeps its previous value.
- PRESCALE=8, no parity, 0x55 with stop bit 0 → STP_ERR pulse at cycle 78, no DATA_VALID.
- RX_IN low for 2 CLKs only, then high → no pulses, FSM in IDLE by cycle 6. Then a 2-cycle glitch during the middle samples of data bit 3 (1 of 3 samples flipped) → bit value unaffected.
- Two back-to-back frames 0x12 and 0x34 with no idle gap → two DATA_VALID pulses 80 cycles apart (PRESCALE=8, no parity). Then RST asserted mid third frame → outputs 0 and no pulse for that frame.
